// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage.
package wb_pkg;

    localparam int unsigned XLEN_DEF   = 64;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned WE_W       = 1;

    localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

    // Buffer entry layout at the default widths; the top re-declares it with its own parameters.
    typedef struct packed {
        logic                  we;
        logic [REG_AW_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_src_sel.sv
// Priority mux over N_SRC result sources; index 0 wins.
module wb_src_sel
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned N_SRC = 2
) (
    input  logic [N_SRC-1:0]      src_ena,
    input  logic [N_SRC*XLEN-1:0] src_data,
    output logic [XLEN-1:0]       sel_data,
    output logic                  any_ena,
    output logic                  multi_ena
);

    // Take the first enabled source; any later enabled source flags a conflict.
    always_comb begin
        sel_data  = '0;
        any_ena   = 1'b0;
        multi_ena = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (src_ena[i]) begin
                if (!any_ena) begin
                    sel_data = src_data[i*XLEN +: XLEN];
                end else begin
                    multi_ena = 1'b1;
                end
                any_ena = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: source select, result FIFO, register-file commit,
// youngest-entry forwarding and retired-instruction counter.
module wb_commit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned N_SRC  = 2,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_SRC-1:0]      in_src_ena,
    input  logic [N_SRC*XLEN-1:0] in_src_data,
    input  logic [REG_AW-1:0]     in_rd_addr,
    input  logic                  wb_stall,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  fwd_valid,
    output logic [REG_AW-1:0]     fwd_addr,
    output logic [XLEN-1:0]       fwd_data,
    output logic [63:0]           instret,
    output logic                  sel_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     instret_q, instret_d;
    logic            sel_err_q, sel_err_d;

    logic [XLEN-1:0] sel_data;
    logic            any_ena, multi_ena;
    logic            full, empty, push, pop;
    logic [PW-1:0]   yng_ptr;
    entry_t          new_entry, head, yng;

    wb_src_sel #(
        .XLEN  (XLEN),
        .N_SRC (N_SRC)
    ) u_src_sel (
        .src_ena   (in_src_ena),
        .src_data  (in_src_data),
        .sel_data  (sel_data),
        .any_ena   (any_ena),
        .multi_ena (multi_ena)
    );

    // Handshake, resolved entry and combinational commit/forward views.
    always_comb begin
        full         = (count_q == CW'(DEPTH));
        empty        = (count_q == '0);
        push         = in_valid && !full;
        pop          = !empty && !wb_stall;
        yng_ptr      = wr_ptr_q - 1'b1;
        head         = mem_q[rd_ptr_q];
        yng          = mem_q[yng_ptr];
        new_entry.we   = any_ena && (in_rd_addr != '0);
        new_entry.rd   = in_rd_addr;
        new_entry.data = sel_data;
        in_ready     = !full;
        rf_we        = pop && head.we;
        rf_waddr     = head.rd;
        rf_wdata     = head.data;
        fwd_valid    = !empty && yng.we;
        fwd_addr     = empty ? '0 : yng.rd;
        fwd_data     = empty ? '0 : yng.data;
        instret      = instret_q;
        sel_err      = sel_err_q;
    end

    // Next-state for pointers, occupancy, counter and sticky error.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        instret_d = instret_q;
        sel_err_d = sel_err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (multi_ena) sel_err_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            instret_d = instret_q + 64'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops all buffered entries uncommitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            instret_q <= '0;
            sel_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            instret_q <= instret_d;
            sel_err_q <= sel_err_d;
            if (push) mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: expected writes are queued at accept and
// popped by a monitor whenever the DUT asserts rf_we.
module tb_wb_commit;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_src_ena;
    logic [127:0] in_src_data;
    logic [4:0]   in_rd_addr;
    logic         wb_stall;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [63:0]  rf_wdata;
    logic         fwd_valid;
    logic [4:0]   fwd_addr;
    logic [63:0]  fwd_data;
    logic [63:0]  instret;
    logic         sel_err;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    wb_commit #(
        .XLEN   (64),
        .N_SRC  (2),
        .REG_AW (5),
        .DEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_src_ena  (in_src_ena),
        .in_src_data (in_src_data),
        .in_rd_addr  (in_rd_addr),
        .wb_stall    (wb_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .instret     (instret),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic send(input logic [1:0] ena, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [4:0] rd, input logic [63:0] exp_data, input bit expect_wr);
        int n = 0;
        exp_t e;
        in_valid    = 1'b1;
        in_src_ena  = ena;
        in_src_data = {d1, d0};
        in_rd_addr  = rd;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else if (expect_wr) begin
            e.addr = rd;
            e.data = exp_data;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every register-file write must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit_addr", 64'(rf_waddr), 64'h0);
                    n_pass = n_pass;
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_addr", 64'(rf_waddr), 64'(e.addr));
                    chk("sb_data", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_src_ena  = '0;
        in_src_data = '0;
        in_rd_addr  = '0;
        wb_stall    = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_sel_err", 64'(sel_err), 64'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Single EXE result
        send(2'b01, 64'h1234, 64'h0, 5'd5, 64'h1234, 1'b1);
        chk("exe_rf_we", 64'(rf_we), 64'd1);
        chk("exe_addr", 64'(rf_waddr), 64'd5);
        chk("exe_data", rf_wdata, 64'h1234);
        chk("exe_fwd_addr", 64'(fwd_addr), 64'd5);
        @(posedge clk); #1;
        chk("exe_instret", instret, 64'd1);

        // Both sources enabled: source 0 wins, sticky error
        send(2'b11, 64'hAA, 64'hBB, 5'd6, 64'hAA, 1'b1);
        chk("prio_data", rf_wdata, 64'hAA);
        chk("prio_sel_err", 64'(sel_err), 64'd1);
        @(posedge clk); #1;
        chk("prio_instret", instret, 64'd2);

        // Write to x0: no write, still counted
        send(2'b01, 64'h55, 64'h0, 5'd0, 64'h0, 1'b0);
        chk("x0_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        chk("x0_instret", instret, 64'd3);

        // No source enabled: no write, still counted
        send(2'b00, 64'h66, 64'h77, 5'd3, 64'h0, 1'b0);
        chk("nosrc_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        chk("nosrc_instret", instret, 64'd4);
        chk("sel_err_sticky", 64'(sel_err), 64'd1);

        // Stall fills the buffer; forwarding shows the youngest entry
        wb_stall = 1'b1;
        send(2'b01, 64'h11, 64'h0, 5'd4, 64'h11, 1'b1);
        send(2'b01, 64'h22, 64'h0, 5'd7, 64'h22, 1'b1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("stall_rf_we", 64'(rf_we), 64'd0);
        chk("fwd_valid_full", 64'(fwd_valid), 64'd1);
        chk("fwd_addr_full", 64'(fwd_addr), 64'd7);
        chk("fwd_data_full", fwd_data, 64'h22);

        in_valid    = 1'b1;
        in_src_ena  = 2'b01;
        in_src_data = {64'h0, 64'h33};
        in_rd_addr  = 5'd9;
        e.addr = 5'd9;
        e.data = 64'h33;
        exp_q.push_back(e);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("full_hold_ready", 64'(in_ready), 64'd0);
        chk("full_hold_instret", instret, 64'd4);
        wb_stall = 1'b0;
        @(negedge clk);
        chk("drain1_addr", 64'(rf_waddr), 64'd4);
        chk("drain1_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("drain2_addr", 64'(rf_waddr), 64'd7);
        chk("drain2_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain3_addr", 64'(rf_waddr), 64'd9);
        chk("drain3_we", 64'(rf_we), 64'd1);
        @(posedge clk); #1;
        chk("drain_instret", instret, 64'd7);
        chk("empty_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("empty_fwd_addr", 64'(fwd_addr), 64'd0);
        chk("empty_fwd_data", fwd_data, 64'd0);
        chk("empty_rf_we", 64'(rf_we), 64'd0);

        // Reset with a full buffer discards it
        wb_stall = 1'b1;
        send(2'b01, 64'h77, 64'h0, 5'd10, 64'h0, 1'b0);
        send(2'b01, 64'h88, 64'h0, 5'd11, 64'h0, 1'b0);
        #3;
        wb_stall = 1'b0;
        rst      = 1'b0;
        #1;
        chk("mid_rst_rf_we", 64'(rf_we), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_instret", instret, 64'd0);
        chk("mid_rst_sel_err", 64'(sel_err), 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_rf_we", 64'(rf_we), 64'd0);
        chk("post_rst_instret", instret, 64'd0);

        // Back-to-back traffic without stalls, including source 1 alone
        @(posedge clk); #1;
        send(2'b01, 64'h100, 64'h0, 5'd1, 64'h100, 1'b1);
        send(2'b10, 64'hDEAD, 64'h200, 5'd2, 64'h200, 1'b1);
        send(2'b01, 64'h300, 64'h0, 5'd31, 64'h300, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("burst_instret", instret, 64'd3);
        chk("burst_sel_err", 64'(sel_err), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
